// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath enables and mux selects for each step.
module mc_control_fsm #(
  parameter bit WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       mem_req,
  output logic       adr_src,
  output logic [2:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       retire,
  output logic       illegal
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R, S_EXEC_I,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR_LINK, S_LUI, S_AUIPC, S_ILLEGAL
  } state_t;

  // Registered per-state controls; *_on_* bits are qualified by same-cycle inputs.
  typedef struct packed {
    logic       pc_write;
    logic       pc_on_rdy;
    logic       pc_on_br;
    logic       ir_on_rdy;
    logic       reg_write;
    logic       mem_write;
    logic       mem_req;
    logic       adr_src;
    logic       imm_dec;
    logic [2:0] imm_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       retire;
    logic       retire_on_rdy;
    logic       illegal;
  } ctrl_t;

  state_t state;
  state_t state_nxt;
  logic   started;
  logic   is_store;
  logic   is_store_nxt;
  logic   rdy;
  ctrl_t  ctrl;

  assign rdy = WAIT_EN ? mem_ready : 1'b1;

  function automatic ctrl_t ctrl_of(input state_t s, input logic st);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:     begin c.mem_req = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10;
                         c.ir_on_rdy = 1'b1; c.pc_on_rdy = 1'b1; end
      S_DECODE:    begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.imm_dec = 1'b1; end
      S_MEMADR:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01;
                         c.imm_src = st ? 3'b001 : 3'b000; end
      S_MEMREAD:   begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      S_MEMWB:     begin c.result_src = 2'b01; c.reg_write = 1'b1; c.retire = 1'b1; end
      S_MEMWRITE:  begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.adr_src = 1'b1;
                         c.retire_on_rdy = 1'b1; end
      S_EXEC_R:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      S_EXEC_I:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      S_ALUWB:     begin c.reg_write = 1'b1; c.retire = 1'b1; end
      S_BRANCH:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.pc_on_br = 1'b1;
                         c.retire = 1'b1; end
      S_JAL:       begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1; end
      S_JALR:      begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.result_src = 2'b10;
                         c.pc_write = 1'b1; end
      S_JALR_LINK: begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
      S_LUI:       begin c.alu_src_a = 2'b11; c.alu_src_b = 2'b01; c.imm_src = 3'b100; end
      S_AUIPC:     begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.imm_src = 3'b100; end
      S_ILLEGAL:   c.illegal = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  // Next-state decode.
  always_comb begin
    state_nxt    = state;
    is_store_nxt = is_store;
    case (state)
      S_FETCH:    if (rdy) state_nxt = S_DECODE;
      S_DECODE: begin
        is_store_nxt = (opcode == OP_STORE);
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_R:              state_nxt = S_EXEC_R;
          OP_I:              state_nxt = S_EXEC_I;
          OP_BR:             state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          OP_JALR:           state_nxt = S_JALR;
          OP_LUI:            state_nxt = S_LUI;
          OP_AUIPC:          state_nxt = S_AUIPC;
          default:           state_nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_nxt = is_store ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (rdy) state_nxt = S_MEMWB;
      S_MEMWRITE: if (rdy) state_nxt = S_FETCH;
      S_MEMWB, S_ALUWB, S_BRANCH: state_nxt = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_JAL, S_JALR_LINK, S_LUI, S_AUIPC: state_nxt = S_ALUWB;
      S_JALR:     state_nxt = S_JALR_LINK;
      S_ILLEGAL:  state_nxt = S_ILLEGAL;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // First edge after reset only reveals FETCH outputs; state advances from then on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      is_store <= 1'b0;
      started  <= 1'b0;
      ctrl     <= '0;
    end else if (!started) begin
      started  <= 1'b1;
      ctrl     <= ctrl_of(S_FETCH, 1'b0);
    end else begin
      state    <= state_nxt;
      is_store <= is_store_nxt;
      ctrl     <= ctrl_of(state_nxt, is_store_nxt);
    end
  end

  assign pc_write   = ctrl.pc_write | (ctrl.pc_on_rdy & rdy) | (ctrl.pc_on_br & branch_taken);
  assign ir_write   = ctrl.ir_on_rdy & rdy;
  assign reg_write  = ctrl.reg_write;
  assign mem_write  = ctrl.mem_write;
  assign mem_req    = ctrl.mem_req;
  assign adr_src    = ctrl.adr_src;
  assign imm_src    = ctrl.imm_dec ? ((opcode == OP_JAL) ? 3'b011 : 3'b010) : ctrl.imm_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign result_src = ctrl.result_src;
  assign retire     = ctrl.retire | (ctrl.retire_on_rdy & rdy);
  assign illegal    = ctrl.illegal;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: random instruction stream scored per retirement
// against latency/event-count expectations, plus directed reset/illegal cases.
module tb_mc_control_fsm;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct {
    int lat; int n_mreq; int n_adr; int n_memw; int n_pcw; int n_irw; int n_regw; int rs;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  bit run   = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       mem_ready = 1'b0;
  logic       branch_taken = 1'b0;
  logic       pc_write, ir_write, reg_write, mem_write, mem_req, adr_src, retire, illegal;
  logic [2:0] imm_src;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;

  logic       nw_rst_n = 1'b0;
  logic [6:0] nw_opcode = 7'd0;
  logic       nw_mem_ready = 1'b0;
  logic       nw_pc_write, nw_ir_write, nw_reg_write, nw_mem_write, nw_mem_req, nw_adr_src;
  logic       nw_retire, nw_illegal;
  logic [2:0] nw_imm_src;
  logic [1:0] nw_alu_src_a, nw_alu_src_b, nw_alu_op, nw_result_src;

  logic [18:0] ov, nw_ov;
  assign ov = {pc_write, ir_write, reg_write, mem_write, mem_req, adr_src, imm_src,
               alu_src_a, alu_src_b, alu_op, result_src, retire, illegal};
  assign nw_ov = {nw_pc_write, nw_ir_write, nw_reg_write, nw_mem_write, nw_mem_req, nw_adr_src,
                  nw_imm_src, nw_alu_src_a, nw_alu_src_b, nw_alu_op, nw_result_src,
                  nw_retire, nw_illegal};

  always #5 clk = ~clk;

  mc_control_fsm u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_write(mem_write), .mem_req(mem_req), .adr_src(adr_src),
    .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .retire(retire), .illegal(illegal)
  );

  mc_control_fsm #(.WAIT_EN(1'b0)) u_dut_nw (
    .clk(clk), .rst_n(nw_rst_n), .opcode(nw_opcode), .mem_ready(nw_mem_ready),
    .branch_taken(branch_taken), .pc_write(nw_pc_write), .ir_write(nw_ir_write),
    .reg_write(nw_reg_write), .mem_write(nw_mem_write), .mem_req(nw_mem_req),
    .adr_src(nw_adr_src), .imm_src(nw_imm_src), .alu_src_a(nw_alu_src_a),
    .alu_src_b(nw_alu_src_b), .alu_op(nw_alu_op), .result_src(nw_result_src),
    .retire(nw_retire), .illegal(nw_illegal)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: accumulates per-instruction events and scores them on each retire.
  int cnt = 0, a_mreq = 0, a_adr = 0, a_memw = 0, a_pcw = 0, a_irw = 0, a_regw = 0;
  always @(negedge clk) begin
    exp_t e;
    if (run) begin
      cnt++;
      a_mreq += int'(mem_req); a_adr += int'(adr_src); a_memw += int'(mem_write);
      a_pcw  += int'(pc_write); a_irw += int'(ir_write); a_regw += int'(reg_write);
      if (reg_write) chk("regw_without_retire", int'(retire), 1);
      if (retire) begin
        if (sb.size() == 0) begin
          chk("unexpected_retire", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("latency", cnt, e.lat);
          chk("mem_req_cycles", a_mreq, e.n_mreq);
          chk("adr_src_cycles", a_adr, e.n_adr);
          chk("mem_write_cycles", a_memw, e.n_memw);
          chk("pc_write_count", a_pcw, e.n_pcw);
          chk("ir_write_count", a_irw, e.n_irw);
          chk("reg_write_count", a_regw, e.n_regw);
          chk("retire_result_src", int'(result_src), e.rs);
        end
        cnt = 0; a_mreq = 0; a_adr = 0; a_memw = 0; a_pcw = 0; a_irw = 0; a_regw = 0;
      end
    end
  end

  function automatic logic [6:0] op_of(input int cls);
    case (cls)
      0: return OP_R;    1: return OP_I;     2: return OP_LUI;   3: return OP_AUIPC;
      4: return OP_LOAD; 5: return OP_STORE; 6: return OP_BR;    7: return OP_JAL;
      default: return OP_JALR;
    endcase
  endfunction

  function automatic int base_lat(input int cls);
    case (cls)
      4: return 5; 6: return 3; 8: return 5;
      default: return 4;
    endcase
  endfunction

  // Issue one instruction: push expectation, then drive its mem_ready timeline.
  task automatic run_instr(input int cls);
    int wf, wm, lat;
    bit mem, bt;
    exp_t e;
    wf  = int'($urandom_range(0, 2));
    wm  = int'($urandom_range(0, 2));
    bt  = 1'($urandom);
    mem = (cls == 4) || (cls == 5);
    lat = base_lat(cls) + wf + (mem ? wm : 0);
    e.lat    = lat;
    e.n_mreq = wf + 1 + (mem ? wm + 1 : 0);
    e.n_adr  = mem ? wm + 1 : 0;
    e.n_memw = (cls == 5) ? wm + 1 : 0;
    e.n_pcw  = 1 + ((cls == 6) ? int'(bt) : 0) + ((cls == 7 || cls == 8) ? 1 : 0);
    e.n_irw  = 1;
    e.n_regw = (cls == 5 || cls == 6) ? 0 : 1;
    e.rs     = (cls == 4) ? 1 : 0;
    sb.push_back(e);
    opcode = op_of(cls);
    branch_taken = bt;
    for (int c = 0; c < lat; c++) begin
      if (c < wf) mem_ready = 1'b0;
      else if (c == wf) mem_ready = 1'b1;
      else if (mem && c >= wf + 3 && c < wf + 3 + wm) mem_ready = 1'b0;
      else if (mem && c == wf + 3 + wm) mem_ready = 1'b1;
      else mem_ready = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // Reset, check quiet outputs, release, and land #1 into the first FETCH cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'(ov), 0);
    rst_n = 1'b1;
    #1;
    chk("pre_first_edge_outputs", int'(ov), 0);
    @(posedge clk); #1;
    chk("first_fetch_mem_req", int'(mem_req), 1);
  endtask

  initial begin
    int n_pre, n_ill, rc;
    // Random instruction stream.
    do_reset();
    run = 1;
    for (int i = 0; i < 40; i++) run_instr((i < 9) ? i : int'($urandom_range(0, 8)));
    @(negedge clk);
    run = 0;
    chk("scoreboard_drained", sb.size(), 0);

    // Unsupported opcode is terminal and cleared only by reset.
    do_reset();
    opcode = 7'b0000000; mem_ready = 1'b1;
    n_pre = 0; n_ill = 0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c <= 2) n_pre += int'(illegal);
      else if (ov == 19'h00001) n_ill++;
      @(posedge clk); #1;
    end
    chk("illegal_before_state", n_pre, 0);
    chk("illegal_held_20", n_ill, 20);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("illegal_async_clear", int'(ov), 0);

    // Async reset in MEMWRITE drops the write before the next edge.
    do_reset();
    opcode = OP_STORE; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    chk("memwrite_active", int'(mem_write), 1);
    chk("memwrite_adr_src", int'(adr_src), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_write", int'(mem_write), 0);
    chk("async_rst_mem_req", int'(mem_req), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("fetch_after_release",
        int'(ov), int'({6'b000010, 3'b000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0}));

    // WAIT_EN=0 ignores a stuck-low mem_ready.
    nw_opcode = OP_I; nw_mem_ready = 1'b0;
    @(negedge clk);
    nw_rst_n = 1'b1;
    rc = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (nw_retire && rc == 0) begin
        rc = c;
        chk("nowait_aluwb_outputs",
            int'(nw_ov), int'({6'b001000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0}));
      end
    end
    chk("nowait_retire_cycle", rc, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
